// File: rtl/tcdm_bank_pkg.sv
// Shared constants, FSM encodings and helpers for the TCDM bank responder.
package tcdm_bank_pkg;

  localparam int unsigned MaxMemLatency = 8;
  localparam int unsigned MaxBeWidth    = 128;
  localparam int unsigned MaxDataWidth  = MaxBeWidth * 8;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  // Expands byte enables to a bit mask; callers zero-extend be and truncate the result.
  function automatic logic [MaxDataWidth-1:0] be_to_bitmask(input logic [MaxBeWidth-1:0] be);
    logic [MaxDataWidth-1:0] mask;
    for (int unsigned b = 0; b < MaxBeWidth; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/tcdm_bank_array.sv
// Behavioural single-port bank: per-byte writes, one-cycle registered read.
// Kept separate so a technology SRAM macro can be dropped in instead.
module tcdm_bank_array
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [AddrMemWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic [DataWidth-1:0]    rdata_o
);

  localparam int unsigned Depth = 2 ** AddrMemWidth;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;
  logic [DataWidth-1:0] wmask;

  assign wmask = DataWidth'(be_to_bitmask(MaxBeWidth'(be_i)));

  // Array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~wmask) | (wdata_i & wmask);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (req_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tcdm_bank_resp.sv
// TCDM bank responder: fixed-latency reads, byte-enabled writes, optional post-reset clear.
module tcdm_bank_resp
  import tcdm_bank_pkg::*;
#(
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned MemLatency   = 1,
  parameter int unsigned ClearOnReset = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cs_i,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    init_busy_o
);

  if (MemLatency < 1 || MemLatency > MaxMemLatency) begin : gen_bad_latency
    $fatal(1, "tcdm_bank_resp: MemLatency must be in 1..%0d", MaxMemLatency);
  end
  if (BeWidth * 8 != DataWidth) begin : gen_bad_be_width
    $fatal(1, "tcdm_bank_resp: BeWidth*8 must equal DataWidth");
  end
  if (DataWidth > MaxDataWidth) begin : gen_bad_data_width
    $fatal(1, "tcdm_bank_resp: DataWidth exceeds %0d", MaxDataWidth);
  end

  localparam logic [0:0] ResetState = (ClearOnReset != 0) ? StClear : StReady;

  logic [0:0]              state_q, state_d;
  logic [AddrMemWidth-1:0] cnt_q, cnt_d;
  logic                    clearing;

  logic                    arr_req;
  logic                    arr_we;
  logic [AddrMemWidth-1:0] arr_addr;
  logic [DataWidth-1:0]    arr_wdata;
  logic [BeWidth-1:0]      arr_be;
  logic [DataWidth-1:0]    arr_rdata;

  assign clearing    = (state_q == StClear);
  assign init_busy_o = clearing;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clearing) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {AddrMemWidth{1'b1}}) begin
        state_d = StReady;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ResetState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear engine owns the array port while running; port requests are dropped.
  always_comb begin
    arr_req   = clearing | cs_i;
    arr_we    = clearing | wen_i;
    arr_addr  = clearing ? cnt_q : add_i;
    arr_wdata = clearing ? '0 : wdata_i;
    arr_be    = clearing ? '1 : be_i;
  end

  tcdm_bank_array #(
    .AddrMemWidth (AddrMemWidth),
    .DataWidth    (DataWidth),
    .BeWidth      (BeWidth)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (arr_req),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .rdata_o (arr_rdata)
  );

  if (MemLatency == 1) begin : gen_no_pipe
    assign rdata_o = arr_rdata;
  end else begin : gen_pipe
    localparam int unsigned Stages = MemLatency - 1;

    logic                 load_acc;
    // vld_q[i] marks fresh data at the input of stage i; stages only move on valid
    // so the last stage holds the most recent result indefinitely.
    logic [Stages-1:0]    vld_q;
    logic [DataWidth-1:0] data_q [Stages];

    assign load_acc = !clearing && cs_i && !wen_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q <= '0;
        for (int unsigned i = 0; i < Stages; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= load_acc;
        for (int unsigned i = 1; i < Stages; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
        if (vld_q[0]) begin
          data_q[0] <= arr_rdata;
        end
        for (int unsigned i = 1; i < Stages; i++) begin
          if (vld_q[i]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end

    assign rdata_o = data_q[Stages-1];
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && clearing && cs_i) begin
      $warning("tcdm_bank_resp: request at addr %0d ignored while clearing", add_i);
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_bank_resp.sv
// Scoreboard bench for tcdm_bank_resp: clear, byte enables, latency, streaming, resets.
module tb_tcdm_bank_resp;

  localparam int unsigned Aw    = 4;
  localparam int unsigned Dw    = 32;
  localparam int unsigned Bw    = 4;
  localparam int unsigned Lat   = 3;
  localparam int unsigned Depth = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic [Aw-1:0] add;
  logic          wen;
  logic [Dw-1:0] wdata;
  logic [Bw-1:0] be;
  logic [Dw-1:0] rdata;
  logic          busy;

  tcdm_bank_resp #(
    .AddrMemWidth (Aw),
    .DataWidth    (Dw),
    .BeWidth      (Bw),
    .MemLatency   (Lat),
    .ClearOnReset (1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cs_i        (cs),
    .add_i       (add),
    .wen_i       (wen),
    .wdata_i     (wdata),
    .be_i        (be),
    .rdata_o     (rdata),
    .init_busy_o (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [Depth];
  logic [31:0] last_res;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: rdata has no valid strobe, so each entry names the cycle it must be visible in.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check($sformatf("rdata@cyc%0d", e.due), rdata, e.data);
    end
  end

  task automatic store(input logic [Aw-1:0] a, input logic [31:0] d, input logic [Bw-1:0] b);
    @(negedge clk);
    cs = 1'b1; wen = 1'b1; add = a; wdata = d; be = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  task automatic load(input logic [Aw-1:0] a);
    @(negedge clk);
    cs = 1'b1; wen = 1'b0; add = a; wdata = 'x; be = '0;
    sb.push_back('{data: model[a], due: cyc + Lat});
    last_res = model[a];
  endtask

  // Load with explicit before/after checks around the latency boundary and a long hold.
  task automatic load_hold(input logic [Aw-1:0] a);
    int k;
    @(negedge clk);
    cs = 1'b1; wen = 1'b0; add = a; wdata = 'x; be = '0;
    k = cyc;
    sb.push_back('{data: last_res, due: k + 1});
    sb.push_back('{data: last_res, due: k + Lat - 1});
    for (int d = Lat; d <= 10; d++) sb.push_back('{data: model[a], due: k + d});
    last_res = model[a];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cs = 1'b0; wen = 1'b0; add = 'x; wdata = 'x; be = '0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Counts busy cycles from now; optionally issues a write to addr 3 during the first cycles.
  task automatic count_busy(input int req_cycles, output int n);
    n = 0;
    #1;
    while (busy === 1'b1 && n < 100) begin
      check("rdata_zero_in_clear", rdata, 32'h0);
      if (n < req_cycles) begin
        cs = 1'b1; wen = 1'b1; add = 4'd3; wdata = 32'hFFFF_FFFF; be = '1;
      end else begin
        cs = 1'b0; wen = 1'b0; add = 'x; wdata = 'x; be = '0;
      end
      n++;
      @(negedge clk);
      #1;
    end
    cs = 1'b0; wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < Depth; i++) model[i] = 32'h0;
    last_res = 32'h0;
    rst = 1'b1; cs = 1'b0; wen = 1'b0; add = '0; wdata = '0; be = '0;
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clear with ignored stores to addr 3 during the first cycles.
    count_busy(3, n);
    check("clear_cycles", 32'(n), 32'd16);
    for (int a = 0; a < Depth; a++) load(4'(a));
    idle(1);
    drain();

    store(4'd5, 32'hAABB_CCDD, 4'b1111);
    store(4'd5, 32'h1122_3344, 4'b0101);
    load(4'd5);
    check("model_be_merge", model[5], 32'hAA22_CC44);
    store(4'd7, 32'hDEAD_BEEF, 4'b1111);
    idle(1);
    drain();

    load_hold(4'd7);
    idle(10);
    drain();

    // Read-after-write and back-to-back streaming.
    store(4'd2, 32'h0000_0001, 4'b1111);
    load(4'd2);
    store(4'd0, 32'h0000_0100, 4'b1111);
    store(4'd1, 32'h0000_0101, 4'b1111);
    load(4'd0);
    load(4'd1);
    load(4'd2);
    store(4'd5, 32'hFFFF_FFFF, 4'b0000);
    load(4'd5);
    idle(1);
    drain();

    // Reset with a load in flight: output clears at once and no late result appears.
    @(negedge clk);
    cs = 1'b1; wen = 1'b0; add = 4'd7;
    @(negedge clk);
    cs = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_inflight_rdata", rdata, 32'h0);
    check("rst_inflight_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < Depth; i++) model[i] = 32'h0;
    last_res = 32'h0;

    // Reset at clear cycle 9: clear restarts from scratch.
    repeat (9) begin
      #1;
      check("rdata_zero_pre_midclear", rdata, 32'h0);
      @(negedge clk);
    end
    check("busy_at_clear_cycle9", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(0, n);
    check("clear_restart_cycles", 32'(n), 32'd16);
    load(4'd5);
    load(4'd7);
    load(4'd3);
    idle(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_resp.md
Name: tcdm_bank_resp

Overview:
- Responder end of the TCDM bank-side port: one single-ported TCDM bank driven by the interconnect's per-bank cs/add/wen/wdata/be outputs.
- Returns read data on rdata_o exactly MemLatency cycles after an accepted read. The interconnect's response path relies on that fixed latency.
- Optional post-reset clear engine zeroes the whole bank.
- Used as the bank model in cluster integration and interconnect benches, and as a synthesizable SRAM wrapper.

Parameters:
- AddrMemWidth, 12, word-address bits per bank; depth = 2**AddrMemWidth words.
- DataWidth, 32, word width in bits.
- BeWidth, DataWidth/8, byte-enable width; one bit per byte.
- MemLatency, 1, read latency in cycles; legal range 1..8.
- ClearOnReset, 1, 1 = zero the whole array after reset release.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cs_i  in  1  chip select; request valid this cycle.
- add_i  in  AddrMemWidth  word address within the bank.
- wen_i  in  1  1 = store, 0 = load.
- wdata_i  in  DataWidth  write data.
- be_i  in  BeWidth  byte enables for stores.
- rdata_o  out  DataWidth  read data.
- init_busy_o  out  1  1 while the clear engine runs; requests are dropped.

Behaviour:
- Reset values:
  - rdata_o = 0.
  - init_busy_o = ClearOnReset.
  - FSM = CLEAR if ClearOnReset, else READY.
  - Clear counter = 0.
  - All latency pipeline stages = 0.
- Reset and the array:
  - Array contents are not reset by rst_i.
  - Only the clear engine writes zeros.
- No backpressure. Every cs_i cycle in READY is accepted; the bank is always ready.
- Store (cs_i=1, wen_i=1, READY):
  - At the edge, byte b of mem[add_i] is updated with wdata_i byte b only where be_i[b]=1.
  - be_i=0 is a legal no-op.
  - rdata_o is unaffected.
- Load (cs_i=1, wen_i=0, READY) issued in cycle t:
  - Array read register captures mem[add_i] at the end of t.
  - MemLatency-1 further register stages follow.
  - rdata_o shows the word from cycle t+MemLatency onward.
  - rdata_o holds that value until the next load result arrives; it does not return to 0.
- Read-after-write: a load issued at t+1 to the address stored at t returns the new data.
- Load stream: back-to-back loads produce back-to-back results in issue order, one per cycle, with no bubbles.
- FSM:
  - CLEAR: each cycle writes 0 to mem[cnt], with full byte enables. cnt increments; AddrMemWidth-bit counter.
  - CLEAR exit: when cnt = 2**AddrMemWidth-1 has been written, go to READY. Clear takes exactly 2**AddrMemWidth cycles. init_busy_o falls in the cycle READY is entered.
  - READY: serves requests. Terminal state until the next reset.
- Requests during CLEAR:
  - Ignored: no write, no pipeline push.
  - rdata_o holds its value.
  - Simulation warning if cs_i=1.
- rst_i asserted mid-clear or mid-read: asynchronous return to reset values. The clear restarts from address 0. In-flight loads are discarded.
- Parameter checks (simulation, at elaboration), each $fatal:
  - MemLatency outside 1..8.
  - BeWidth*8 != DataWidth.
- X on add_i/wdata_i while cs_i=0 has no effect on any state.

Decomposition:
- Package tcdm_bank_pkg:
  - FSM state enum {CLEAR, READY}.
  - Constant MaxMemLatency = 8.
  - Function be_to_bitmask(be) expanding byte enables to a DataWidth bit mask.
- Sub-module tcdm_bank_array:
  - Behavioural single-port array with per-byte write and a 1-cycle registered read.
  - Isolated so a technology SRAM macro can replace it.
- The top level holds:
  - the FSM and clear counter;
  - the request mux between clear writes and port requests;
  - the MemLatency-1 stage data pipeline.

Test Plan:
- Clear: ClearOnReset=1, AddrMemWidth=4, release rst_i -> init_busy_o=1 for exactly 16 cycles, then 0. Loads of addr 0..15 all return 0x00000000.
- Byte-enable store: store 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101; load addr 5 -> 0xAA22CC44.
- Latency: MemLatency=3, load addr 7 (holding 0xDEADBEEF) at cycle t -> rdata_o changes to 0xDEADBEEF exactly at t+3 and is held through t+10 with cs_i=0.
- Streaming/RAW:
  - Store 0x1 to addr 2 at t, load addr 2 at t+1 -> 0x1 at t+1+MemLatency.
  - Loads of addr 0,1,2 in consecutive cycles -> three results in order, consecutive cycles.
- Requests during clear: cs_i=1, wen_i=1, addr 3, data 0xFFFFFFFF during CLEAR -> ignored; after clear, load addr 3 -> 0.
- Reset mid-operation:
  - Assert rst_i at clear cycle 9 -> clear restarts; init_busy_o high another 2**AddrMemWidth cycles.
  - Assert rst_i with a load in flight -> rdata_o = 0 immediately; no late result appears.
